mem_access_ctrl: RTL

//  MEM-stage data-bus controller. Sits between ex_mem and mem_wb and performs loads/stores over a req/ack bus.

---
 rtl/mem_access_ctrl_if.sv | 23 ++
 rtl/mem_access_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl_if.sv
// Data-bus req/ack handshake between the MEM-stage controller (master) and memory (slave).
interface mem_access_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              bus_req;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [3:0]        bus_sel;
    logic [DATA_W-1:0] bus_wdata;
    logic              bus_ack;
    logic [DATA_W-1:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_sel, bus_wdata,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_sel, bus_wdata,
        output bus_ack, bus_rdata
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-bus controller: issues loads/stores over req/ack, stalls the pipe until ack,
// aligns/extends load data, builds big-endian byte selects and handles LL/SC.
module mem_access_ctrl #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        mem_op,
    input  logic [4:0]        mem_wd_i,
    input  logic              mem_wreg_i,
    input  logic [DATA_W-1:0] mem_result_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] mem_reg2_i,
    input  logic              LLbit_i,
    input  logic              flush,
    input  logic              stall_mem,
    mem_access_ctrl_if.master bus,
    output logic [4:0]        mem_wd_o,
    output logic              mem_wreg_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic              LLbit_we_o,
    output logic              LLbit_value_o,
    output logic              adel_o,
    output logic              ades_o,
    output logic              stallreq
);
    typedef enum logic [3:0] {
        OP_NOP = 4'd0, OP_LB = 4'd1, OP_LBU = 4'd2, OP_LH = 4'd3, OP_LHU = 4'd4, OP_LW = 4'd5,
        OP_SB  = 4'd6, OP_SH = 4'd7, OP_SW  = 4'd8, OP_LL = 4'd9, OP_SC  = 4'd10
    } op_e;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE, S_DRAIN} state_e;

    state_e            state;
    logic [DATA_W-1:0] rdata_q;
    logic              q_we;
    logic [ADDR_W-1:0] q_addr;
    logic [3:0]        q_sel;
    logic [DATA_W-1:0] q_wdata;

    op_e               op;
    logic              is_load, is_store, is_mem, misaligned, sc_fail, need_bus;
    logic [3:0]        sel_c;
    logic [DATA_W-1:0] wdata_c, load_val;
    logic [ADDR_W-1:0] addr_c;
    logic [7:0]        lane_b;
    logic [15:0]       lane_h;

    always_comb begin
        op         = op_e'(mem_op);
        is_load    = op inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_LL};
        is_store   = op inside {OP_SB, OP_SH, OP_SW, OP_SC};
        is_mem     = is_load || is_store;
        misaligned = ((op inside {OP_LH, OP_LHU, OP_SH}) && mem_addr_i[0])
                  || ((op inside {OP_LW, OP_LL, OP_SW, OP_SC}) && (mem_addr_i[1:0] != 2'b00));
        sc_fail    = (op == OP_SC) && !LLbit_i && !misaligned;
        need_bus   = is_mem && !misaligned && !sc_fail;
        addr_c     = {mem_addr_i[ADDR_W-1:2], 2'b00};

        sel_c   = 4'b1111;
        wdata_c = '0;
        case (op)
            OP_SB: begin
                sel_c   = 4'b1000 >> mem_addr_i[1:0];
                wdata_c = {4{mem_reg2_i[7:0]}};
            end
            OP_SH: begin
                sel_c   = mem_addr_i[1] ? 4'b0011 : 4'b1100;
                wdata_c = {2{mem_reg2_i[15:0]}};
            end
            OP_SW, OP_SC: wdata_c = mem_reg2_i;
            default: ;
        endcase

        // Big-endian lanes: byte offset 0 lives in bits 31:24.
        case (mem_addr_i[1:0])
            2'd0:    lane_b = rdata_q[31:24];
            2'd1:    lane_b = rdata_q[23:16];
            2'd2:    lane_b = rdata_q[15:8];
            default: lane_b = rdata_q[7:0];
        endcase
        lane_h = mem_addr_i[1] ? rdata_q[15:0] : rdata_q[31:16];
        case (op)
            OP_LB:   load_val = {{24{lane_b[7]}}, lane_b};
            OP_LBU:  load_val = {24'd0, lane_b};
            OP_LH:   load_val = {{16{lane_h[15]}}, lane_h};
            OP_LHU:  load_val = {16'd0, lane_h};
            default: load_val = rdata_q;
        endcase
    end

    always_comb begin
        bus.bus_req   = 1'b0;
        bus.bus_we    = 1'b0;
        bus.bus_addr  = '0;
        bus.bus_sel   = '0;
        bus.bus_wdata = '0;
        mem_wd_o      = '0;
        mem_wreg_o    = 1'b0;
        mem_wdata_o   = '0;
        LLbit_we_o    = 1'b0;
        LLbit_value_o = 1'b0;
        adel_o        = 1'b0;
        ades_o        = 1'b0;
        stallreq      = 1'b0;
        if (!rst) begin
            unique case (state)
                S_IDLE: begin
                    if (!flush) begin
                        if (!is_mem) begin
                            mem_wd_o    = mem_wd_i;
                            mem_wreg_o  = mem_wreg_i;
                            mem_wdata_o = mem_result_i;
                        end else if (misaligned) begin
                            adel_o   = is_load;
                            ades_o   = is_store;
                            mem_wd_o = mem_wd_i;
                        end else if (sc_fail) begin
                            mem_wd_o   = mem_wd_i;
                            mem_wreg_o = 1'b1;
                        end else begin
                            bus.bus_req   = 1'b1;
                            bus.bus_we    = is_store;
                            bus.bus_addr  = addr_c;
                            bus.bus_sel   = sel_c;
                            bus.bus_wdata = wdata_c;
                            stallreq      = 1'b1;
                        end
                    end
                end
                S_WAIT, S_DRAIN: begin
                    // Request fields replay from the issue-cycle copy so a flushed ex_mem cannot disturb them.
                    bus.bus_req   = 1'b1;
                    bus.bus_we    = q_we;
                    bus.bus_addr  = q_addr;
                    bus.bus_sel   = q_sel;
                    bus.bus_wdata = q_wdata;
                    if (!flush) begin
                        if (state == S_WAIT || is_mem) begin
                            stallreq = 1'b1;
                        end else begin
                            mem_wd_o    = mem_wd_i;
                            mem_wreg_o  = mem_wreg_i;
                            mem_wdata_o = mem_result_i;
                        end
                    end
                end
                S_DONE: begin
                    if (!flush) begin
                        mem_wd_o = mem_wd_i;
                        if (op == OP_SC) begin
                            mem_wreg_o  = 1'b1;
                            mem_wdata_o = 32'd1;
                            LLbit_we_o  = 1'b1;
                        end else if (is_load) begin
                            mem_wreg_o    = mem_wreg_i;
                            mem_wdata_o   = load_val;
                            LLbit_we_o    = (op == OP_LL);
                            LLbit_value_o = (op == OP_LL);
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            rdata_q <= '0;
            q_we    <= 1'b0;
            q_addr  <= '0;
            q_sel   <= '0;
            q_wdata <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (!flush && need_bus) begin
                        q_we    <= is_store;
                        q_addr  <= addr_c;
                        q_sel   <= sel_c;
                        q_wdata <= wdata_c;
                        if (bus.bus_ack) begin
                            rdata_q <= bus.bus_rdata;
                            state   <= S_DONE;
                        end else begin
                            state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (flush) begin
                        state <= bus.bus_ack ? S_IDLE : S_DRAIN;
                    end else if (bus.bus_ack) begin
                        rdata_q <= bus.bus_rdata;
                        state   <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (flush || !stall_mem) state <= S_IDLE;
                end
                S_DRAIN: begin
                    if (bus.bus_ack) state <= S_IDLE;
                end
            endcase
        end
    end
endmodule
